flag_branch_unit: RTL and testbench
===================================

Name: flag_branch_unit

Overview:
- Consumer end of the ALU flag interface: latches N/Z/C/V from the 64-bit add/sub datapath when a flag-setting instruction (ADDS/SUBS) completes.
- Evaluates B.cond, CBZ, CBNZ and B against the stored (or same-cycle bypassed) flags and produces a registered branch-taken decision for the fetch stage.
- Sits between the ALU flag outputs and the PC-select logic of the CPU.

Parameters:
- BYPASS, 1, 1 = a branch issued in the same cycle as a flag write uses the incoming flags; 0 = it uses the stored flags.
- WIDTH, 64, width of the register operand tested by CBZ/CBNZ.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- flag_wr  input  1  latch incoming flags this cycle.
- in_negative  input  1  ALU negative flag.
- in_zero  input  1  ALU zero flag.
- in_carryout  input  1  ALU carryout flag.
- in_overflow  input  1  ALU overflow flag.
- br_valid  input  1  branch query present this cycle.
- br_type  input  2  00 B.cond, 01 CBZ, 10 CBNZ, 11 B (unconditional).
- br_cond  input  4  ARM condition code, used only when br_type=00.
- reg_val  input  WIDTH  register operand for CBZ/CBNZ.
- flags_q  output  4  stored flags {N,Z,C,V}.
- flags_valid  output  1  at least one flag write has occurred since reset.
- taken  output  1  branch decision, registered.
- taken_valid  output  1  taken is meaningful this cycle.
- cond_err  output  1  pulse: B.cond evaluated while no valid flags existed.

Behaviour:
- Decided: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset: flags_q=0000, flags_valid=0, taken=0, taken_valid=0, cond_err=0. Reset is asynchronous and clears outputs immediately, including mid-query.
- Flag register: on a rising edge with flag_wr=1, flags_q <= {in_negative,in_zero,in_carryout,in_overflow} and flags_valid <= 1. Without flag_wr, flags_q holds. flags_valid stays 1 until reset.
- Effective flags (F): if BYPASS=1 and flag_wr=1 in the query cycle, F = incoming flags; otherwise F = flags_q.
- Condition decode on F, codes 0-F:
  - EQ Z; NE !Z; HS C; LO !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !(C&!Z); GE N==V; LT N!=V; GT !Z&(N==V); LE !(!Z&(N==V)).
  - AL 1; NV 1.
- Type decode:
  - B.cond: the condition result.
  - CBZ: reg_val==0, full WIDTH compare.
  - CBNZ: reg_val!=0.
  - B: 1.
  - CBZ, CBNZ and B ignore flags entirely.
- Valid-flags gate: B.cond with no valid flags -> taken=0 and cond_err=1 for one cycle, except AL/NV, which are taken with no error.
  - "No valid flags" means flags_valid=0, and additionally (BYPASS=1 and flag_wr=1) is false in that cycle.
- Latency: one cycle. A query at edge k yields taken/taken_valid/cond_err valid after edge k+1.
  - Fully pipelined: a new query is accepted every cycle, with no stall and no busy output.
- br_valid=0: taken_valid <= 0, taken <= 0, cond_err <= 0.
- Simultaneous flag_wr and br_valid with BYPASS=0: the branch uses the old flags_q, and the new flags are visible from the next query onward.

Test Plan:
- Reset, then B.cond EQ (br_cond=0) with no prior flag write -> next cycle taken=0, taken_valid=1, cond_err=1; then the same query with br_cond=E -> taken=1, cond_err=0.
- flag_wr with N=0,Z=1,C=1,V=0, then B.cond EQ -> taken=1; NE -> 0; HS -> 1; HI -> 0; LS -> 1; GE -> 1; GT -> 0.
- flag_wr N=1,V=0 (e.g. 2-5 result) then LT -> 1, GE -> 0; flag_wr N=0,V=1 (0x8000000000000000-1) then LT -> 1, VS -> 1, MI -> 0.
- CBZ with reg_val=64'h0 -> taken=1; reg_val=64'h8000000000000000 -> 0; CBNZ with reg_val=64'h1 -> 1; B -> 1 regardless of flags.
- Stored Z=0, then in the same cycle flag_wr Z=1 and B.cond EQ: BYPASS=1 -> taken=1; BYPASS=0 -> taken=0, and a following EQ query -> 1.
- Back-to-back queries EQ, NE, AL on three consecutive cycles -> three consecutive taken_valid=1 results in order; assert reset mid-stream -> taken, taken_valid and flags_q clear immediately and flags_valid=0.

Source files
------------

// File: rtl/flag_branch_unit_if.sv
// Flag/branch bus between the ALU flag producer, branch issue and the PC-select consumer.
// Latency: none, plain wires; the registered results come from flag_branch_unit.
// Backpressure: none, the unit accepts one query and one flag write every cycle.
// Ports: master = ALU/issue side (drives flags and queries, sees results);
//        slave  = flag_branch_unit (consumes flags and queries, drives results).
interface flag_branch_unit_if #(
    parameter int WIDTH = 64
);
    logic             flag_wr;
    logic             in_negative;
    logic             in_zero;
    logic             in_carryout;
    logic             in_overflow;
    logic             br_valid;
    logic [1:0]       br_type;
    logic [3:0]       br_cond;
    logic [WIDTH-1:0] reg_val;
    logic [3:0]       flags_q;
    logic             flags_valid;
    logic             taken;
    logic             taken_valid;
    logic             cond_err;

    modport master (
        output flag_wr, in_negative, in_zero, in_carryout, in_overflow,
        output br_valid, br_type, br_cond, reg_val,
        input  flags_q, flags_valid, taken, taken_valid, cond_err
    );

    modport slave (
        input  flag_wr, in_negative, in_zero, in_carryout, in_overflow,
        input  br_valid, br_type, br_cond, reg_val,
        output flags_q, flags_valid, taken, taken_valid, cond_err
    );
endinterface

// File: rtl/flag_branch_unit.sv
// NZCV flag register plus B.cond/CBZ/CBNZ/B resolver producing a taken decision for fetch.
// Latency: one cycle from query to taken/taken_valid/cond_err; flags_q updates on the write edge.
// Backpressure: none, fully pipelined; a new query and a flag write are accepted every cycle.
// Ports: clk, reset (async, active-high); bus (slave modport):
//        flag_wr + in_{negative,zero,carryout,overflow} in, br_valid/br_type/br_cond/reg_val in,
//        flags_q/flags_valid/taken/taken_valid/cond_err out.
module flag_branch_unit #(
    parameter bit BYPASS = 1'b1,
    parameter int WIDTH  = 64
) (
    input  logic               clk,
    input  logic               reset,
    flag_branch_unit_if.slave  bus
);
    localparam logic [WIDTH-1:0] ZERO = '0;

    logic [3:0] flags_r;
    logic       flags_valid_r;
    logic       taken_r;
    logic       taken_valid_r;
    logic       cond_err_r;

    logic [3:0] in_flags;
    logic [3:0] eff;
    logic       use_in;
    logic       have_flags;
    logic       cond_hit;
    logic       dec_taken;
    logic       dec_err;

    assign in_flags = {bus.in_negative, bus.in_zero, bus.in_carryout, bus.in_overflow};

    // Same-cycle flag write forwards straight into the query when bypassing is enabled;
    // such a write also counts as "flags exist" for the error gate.
    assign use_in     = BYPASS && bus.flag_wr;
    assign eff        = use_in ? in_flags : flags_r;
    assign have_flags = flags_valid_r || use_in;

    always_comb begin
        cond_hit = 1'b0;
        case (bus.br_cond)
            4'h0: cond_hit =  eff[2];                          // EQ
            4'h1: cond_hit = !eff[2];                          // NE
            4'h2: cond_hit =  eff[1];                          // HS
            4'h3: cond_hit = !eff[1];                          // LO
            4'h4: cond_hit =  eff[3];                          // MI
            4'h5: cond_hit = !eff[3];                          // PL
            4'h6: cond_hit =  eff[0];                          // VS
            4'h7: cond_hit = !eff[0];                          // VC
            4'h8: cond_hit =  (eff[1] && !eff[2]);             // HI
            4'h9: cond_hit = !(eff[1] && !eff[2]);             // LS
            4'hA: cond_hit =  (eff[3] == eff[0]);              // GE
            4'hB: cond_hit =  (eff[3] != eff[0]);              // LT
            4'hC: cond_hit =  (!eff[2] && (eff[3] == eff[0])); // GT
            4'hD: cond_hit = !(!eff[2] && (eff[3] == eff[0])); // LE
            default: cond_hit = 1'b1;                          // AL, NV
        endcase
    end

    always_comb begin
        dec_taken = 1'b0;
        dec_err   = 1'b0;
        case (bus.br_type)
            2'b00: begin
                // AL/NV (codes E/F) never depend on flags, so they skip the error gate.
                if (!have_flags && (bus.br_cond[3:1] != 3'b111)) begin
                    dec_err = 1'b1;
                end else begin
                    dec_taken = cond_hit;
                end
            end
            2'b01:   dec_taken = (bus.reg_val == ZERO);
            2'b10:   dec_taken = (bus.reg_val != ZERO);
            default: dec_taken = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r       <= 4'b0000;
            flags_valid_r <= 1'b0;
            taken_r       <= 1'b0;
            taken_valid_r <= 1'b0;
            cond_err_r    <= 1'b0;
        end else begin
            if (bus.flag_wr) begin
                flags_r       <= in_flags;
                flags_valid_r <= 1'b1;
            end
            taken_valid_r <= bus.br_valid;
            taken_r       <= bus.br_valid && dec_taken;
            cond_err_r    <= bus.br_valid && dec_err;
        end
    end

    assign bus.flags_q     = flags_r;
    assign bus.flags_valid = flags_valid_r;
    assign bus.taken       = taken_r;
    assign bus.taken_valid = taken_valid_r;
    assign bus.cond_err    = cond_err_r;
endmodule

// File: tb/tb_flag_branch_unit.sv
// Bench for flag_branch_unit: BYPASS=1 and BYPASS=0 instances share one stimulus stream.
// Expected results are queued at issue time and popped by a negedge monitor.
// Ports: none (top-level bench).
module tb_flag_branch_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        flag_wr  = 1'b0;
    logic [3:0]  nf       = 4'b0000;
    logic        br_valid = 1'b0;
    logic [1:0]  br_type  = 2'b00;
    logic [3:0]  br_cond  = 4'h0;
    logic [63:0] reg_val  = 64'h0;

    flag_branch_unit_if #(.WIDTH(64)) b1 ();
    flag_branch_unit_if #(.WIDTH(64)) b0 ();

    assign b1.flag_wr     = flag_wr;
    assign b1.in_negative = nf[3];
    assign b1.in_zero     = nf[2];
    assign b1.in_carryout = nf[1];
    assign b1.in_overflow = nf[0];
    assign b1.br_valid    = br_valid;
    assign b1.br_type     = br_type;
    assign b1.br_cond     = br_cond;
    assign b1.reg_val     = reg_val;
    assign b0.flag_wr     = flag_wr;
    assign b0.in_negative = nf[3];
    assign b0.in_zero     = nf[2];
    assign b0.in_carryout = nf[1];
    assign b0.in_overflow = nf[0];
    assign b0.br_valid    = br_valid;
    assign b0.br_type     = br_type;
    assign b0.br_cond     = br_cond;
    assign b0.reg_val     = reg_val;

    flag_branch_unit #(.BYPASS(1'b1), .WIDTH(64)) dut1 (.clk(clk), .reset(reset), .bus(b1));
    flag_branch_unit #(.BYPASS(1'b0), .WIDTH(64)) dut0 (.clk(clk), .reset(reset), .bus(b0));

    typedef struct {
        int         due;
        logic       tk;
        logic       er;
        logic [3:0] fl;
        logic       fv;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: architectural flags as seen by software.
    logic [3:0] m_flags = 4'b0000;
    logic       m_fv    = 1'b0;

    // Condition table: pairs of codes share one test, the odd code negates it (except NV).
    function automatic logic ref_cond(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cy, v;
        logic [7:0] tests_v;
        {n, z, cy, v} = f;
        tests_v = {1'b1, (!z && (n == v)), (n == v), (cy && !z), v, n, cy, z};
        return tests_v[c[3:1]] ^ (c[0] && (c != 4'hF));
    endfunction

    task automatic ref_branch(input int bp, input logic fw, input logic [3:0] f,
                              input logic [1:0] t, input logic [3:0] c, input logic [63:0] rv,
                              output logic tk, output logic er);
        logic [3:0] ff;
        logic       have;
        ff   = (bp == 1 && fw) ? f : m_flags;
        have = m_fv || (bp == 1 && fw);
        tk = 1'b0;
        er = 1'b0;
        case (t)
            2'd0: begin
                if (!have && c < 4'hE) er = 1'b1;
                else tk = ref_cond(ff, c);
            end
            2'd1: tk = (rv == 64'd0);
            2'd2: tk = (rv != 64'd0);
            default: tk = 1'b1;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic fw, input logic [3:0] f, input logic bv,
                         input logic [1:0] t, input logic [3:0] c, input logic [63:0] rv);
        exp_t e;
        @(posedge clk);
        #1;
        flag_wr  = fw;
        nf       = f;
        br_valid = bv;
        br_type  = t;
        br_cond  = c;
        reg_val  = rv;
        if (bv) begin
            for (int bp = 0; bp < 2; bp++) begin
                e.due = cyc + 1;
                ref_branch(bp, fw, f, t, c, rv, e.tk, e.er);
                e.fl = fw ? f : m_flags;
                e.fv = m_fv | fw;
                if (bp == 1) q1.push_back(e);
                else q0.push_back(e);
            end
        end
        if (fw) begin
            m_flags = f;
            m_fv    = 1'b1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, " bp1 taken_valid"}, 32'(b1.taken_valid), 32'd0);
        chk({tag, " bp1 taken"},       32'(b1.taken),       32'd0);
        chk({tag, " bp1 cond_err"},    32'(b1.cond_err),    32'd0);
        chk({tag, " bp1 flags_q"},     32'(b1.flags_q),     32'd0);
        chk({tag, " bp1 flags_valid"}, 32'(b1.flags_valid), 32'd0);
        chk({tag, " bp0 taken_valid"}, 32'(b0.taken_valid), 32'd0);
        chk({tag, " bp0 flags_q"},     32'(b0.flags_q),     32'd0);
        chk({tag, " bp0 flags_valid"}, 32'(b0.flags_valid), 32'd0);
    endtask

    // Asserted after the negedge check so the visible result has been scored;
    // anything still in flight is discarded with the queues.
    task automatic apply_reset(input string tag);
        @(posedge clk);
        #6;
        reset    = 1'b1;
        br_valid = 1'b0;
        flag_wr  = 1'b0;
        q0.delete();
        q1.delete();
        m_flags = 4'b0000;
        m_fv    = 1'b0;
        #1;
        check_reset_state(tag);
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic mon(input int bp, input logic tv, input logic tk, input logic er,
                       input logic [3:0] fl, input logic fv);
        exp_t e;
        int   sz;
        sz = (bp == 1) ? q1.size() : q0.size();
        while (sz > 0) begin
            e = (bp == 1) ? q1[0] : q0[0];
            if (e.due >= cyc) break;
            tests++;
            fails++;
            $display("FAIL bp%0d missing result: taken_valid absent at cycle %0d, required 1", bp, e.due);
            if (bp == 1) void'(q1.pop_front());
            else void'(q0.pop_front());
            sz--;
        end
        if (tv) begin
            tests++;
            if (sz == 0 || e.due != cyc) begin
                fails++;
                $display("FAIL bp%0d unexpected result: taken_valid=1 at cycle %0d, required 0", bp, cyc);
            end else begin
                if (bp == 1) void'(q1.pop_front());
                else void'(q0.pop_front());
                if ({tk, er, fv, fl} !== {e.tk, e.er, e.fv, e.fl}) begin
                    fails++;
                    $display("FAIL bp%0d result cycle %0d: {taken,cond_err,flags_valid,flags_q}=%b required %b",
                             bp, cyc, {tk, er, fv, fl}, {e.tk, e.er, e.fv, e.fl});
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon(1, b1.taken_valid, b1.taken, b1.cond_err, b1.flags_q, b1.flags_valid);
            mon(0, b0.taken_valid, b0.taken, b0.cond_err, b0.flags_q, b0.flags_valid);
        end
    end

    initial begin
        #3;
        check_reset_state("reset");
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        // B.cond before any flag write: EQ errors, AL is taken.
        issue(0, 4'b0000, 1, 2'd0, 4'h0, 64'd0);
        issue(0, 4'b0000, 1, 2'd0, 4'hE, 64'd0);

        // N=0 Z=1 C=1 V=0
        issue(1, 4'b0110, 0, 2'd0, 4'h0, 64'd0);
        issue(0, 4'b0000, 1, 2'd0, 4'h0, 64'd0);  // EQ
        issue(0, 4'b0000, 1, 2'd0, 4'h1, 64'd0);  // NE
        issue(0, 4'b0000, 1, 2'd0, 4'h2, 64'd0);  // HS
        issue(0, 4'b0000, 1, 2'd0, 4'h8, 64'd0);  // HI
        issue(0, 4'b0000, 1, 2'd0, 4'h9, 64'd0);  // LS
        issue(0, 4'b0000, 1, 2'd0, 4'hA, 64'd0);  // GE
        issue(0, 4'b0000, 1, 2'd0, 4'hC, 64'd0);  // GT

        // 2-5: N=1 V=0
        issue(1, 4'b1000, 0, 2'd0, 4'h0, 64'd0);
        issue(0, 4'b0000, 1, 2'd0, 4'hB, 64'd0);  // LT
        issue(0, 4'b0000, 1, 2'd0, 4'hA, 64'd0);  // GE
        // 0x8000000000000000-1: N=0 C=1 V=1
        issue(1, 4'b0011, 0, 2'd0, 4'h0, 64'd0);
        issue(0, 4'b0000, 1, 2'd0, 4'hB, 64'd0);  // LT
        issue(0, 4'b0000, 1, 2'd0, 4'h6, 64'd0);  // VS
        issue(0, 4'b0000, 1, 2'd0, 4'h4, 64'd0);  // MI

        // Register-operand and unconditional branches.
        issue(0, 4'b0000, 1, 2'd1, 4'h0, 64'h0);
        issue(0, 4'b0000, 1, 2'd1, 4'h0, 64'h8000000000000000);
        issue(0, 4'b0000, 1, 2'd2, 4'h0, 64'h1);
        issue(0, 4'b0000, 1, 2'd2, 4'h0, 64'h0);
        issue(0, 4'b0000, 1, 2'd3, 4'h1, 64'h5);

        // Stored Z=0, then same-cycle Z=1 write with EQ, then EQ again.
        issue(1, 4'b0000, 0, 2'd0, 4'h0, 64'd0);
        issue(1, 4'b0100, 1, 2'd0, 4'h0, 64'd0);
        issue(0, 4'b0000, 1, 2'd0, 4'h0, 64'd0);

        // First-ever flag write coincides with the query: only the bypass unit has flags.
        apply_reset("reset after bypass");
        issue(1, 4'b0100, 1, 2'd0, 4'h0, 64'd0);
        issue(0, 4'b0000, 1, 2'd0, 4'h1, 64'd0);

        // Back-to-back EQ, NE, AL then reset while the last result is visible.
        issue(0, 4'b0000, 1, 2'd0, 4'h0, 64'd0);
        issue(0, 4'b0000, 1, 2'd0, 4'h1, 64'd0);
        issue(0, 4'b0000, 1, 2'd0, 4'hE, 64'd0);
        apply_reset("mid-stream reset");

        for (int i = 0; i < 400; i++) begin
            logic [63:0] rv;
            rv = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            issue(logic'($urandom_range(0, 3) == 0), 4'($urandom), logic'($urandom_range(0, 4) != 0),
                  2'($urandom), 4'($urandom), rv);
            if (i % 100 == 99) apply_reset("random reset");
        end

        issue(0, 4'b0000, 0, 2'd0, 4'h0, 64'd0);
        repeat (3) @(posedge clk);
        #6;
        chk("bp1 drained", 32'(q1.size()), 32'd0);
        chk("bp0 drained", 32'(q0.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
